// File: rtl/jt51_phinc_meas.sv
// jt51_phinc_meas: measures the phase increment of one slot of the JT51 PG output stream
//   clk, rst           clock; asynchronous active-high reset
//   i_cen, i_zero      slot advance enable; slot-0 marker (qualified by i_cen)
//   i_phase_in         PG phase for the current slot
//   i_start, i_sel_slot measurement request pulse and the slot to measure
//   o_busy             measurement armed or running
//   o_meas_valid/i_meas_ready  result handshake
//   o_meas_sum, o_meas_inc, o_meas_wraps  sum of 2^NLOG increments, average, wrap count
module jt51_phinc_meas #(
   parameter int PW   = 20,
   parameter int NLOG = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cen,
   input  logic               i_zero,
   input  logic [PW-1:0]      i_phase_in,
   input  logic               i_start,
   input  logic [4:0]         i_sel_slot,
   output logic               o_busy,
   output logic               o_meas_valid,
   input  logic               i_meas_ready,
   output logic [PW+NLOG-1:0] o_meas_sum,
   output logic [PW-1:0]      o_meas_inc,
   output logic [NLOG:0]      o_meas_wraps
);
   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
   localparam logic [NLOG:0] LAST = (NLOG+1)'((1 << NLOG) - 1);
   state_t             r_st;
   logic [4:0]         r_cnt, r_sel;
   logic [PW-1:0]      r_prev;
   logic [PW+NLOG-1:0] r_sum;
   logic [NLOG:0]      r_wraps, r_n;
   logic               w_smp;
   logic [PW-1:0]      w_delta;
   logic [PW+NLOG-1:0] w_sum;
   logic [NLOG:0]      w_wraps;
   // slot 0 is flagged by i_zero rather than the counter, so the counter resyncs every frame
   assign w_smp   = i_cen && ((i_zero ? 5'd0 : r_cnt) == r_sel);
   assign w_delta = i_phase_in - r_prev;
   assign w_sum   = r_sum + (PW+NLOG)'(w_delta);
   assign w_wraps = r_wraps + (NLOG+1)'(i_phase_in < r_prev);
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else if (i_cen) r_cnt <= i_zero ? 5'd1 : r_cnt + 5'd1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_st         <= IDLE;
         r_sel        <= '0;
         r_prev       <= '0;
         r_sum        <= '0;
         r_wraps      <= '0;
         r_n          <= '0;
         o_busy       <= 1'b0;
         o_meas_valid <= 1'b0;
         o_meas_sum   <= '0;
         o_meas_inc   <= '0;
         o_meas_wraps <= '0;
      end else
         case (r_st)
            IDLE: if (i_start) begin
               r_sel   <= i_sel_slot;
               r_sum   <= '0;
               r_wraps <= '0;
               r_n     <= '0;
               o_busy  <= 1'b1;
               r_st    <= ARM;
            end
            // first visit only establishes the reference phase
            ARM: if (w_smp) begin
               r_prev <= i_phase_in;
               r_st   <= RUN;
            end
            RUN: if (w_smp) begin
               r_sum   <= w_sum;
               r_wraps <= w_wraps;
               r_prev  <= i_phase_in;
               r_n     <= r_n + (NLOG+1)'(1);
               if (r_n == LAST) begin
                  r_st         <= DONE;
                  o_busy       <= 1'b0;
                  o_meas_valid <= 1'b1;
                  o_meas_sum   <= w_sum;
                  o_meas_inc   <= w_sum[PW+NLOG-1:NLOG];
                  o_meas_wraps <= w_wraps;
               end
            end
            // handshake is honoured regardless of i_cen
            DONE: if (i_meas_ready) begin
               r_st         <= IDLE;
               o_meas_valid <= 1'b0;
            end
            default: r_st <= IDLE;
         endcase
endmodule

// File: tb/tb_jt51_phinc_meas.sv
// tb_jt51_phinc_meas: directed-vector bench for jt51_phinc_meas (PW=20, NLOG=4)
module tb_jt51_phinc_meas;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b1;
   logic        zero = 1'b0;
   logic [19:0] phase_in = '0;
   logic        start = 1'b0;
   logic [4:0]  sel = '0;
   logic        busy, valid;
   logic        ready = 1'b0;
   logic [23:0] sum;
   logic [19:0] inc_o;
   logic [4:0]  wraps;
   logic [19:0] ph [32];
   logic [19:0] stp [32];
   logic [4:0]  ts = '0;
   logic        gate = 1'b0;
   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;

   jt51_phinc_meas #(.PW(20), .NLOG(4)) dut (
      .clk(clk), .rst(rst), .i_cen(cen), .i_zero(zero), .i_phase_in(phase_in),
      .i_start(start), .i_sel_slot(sel), .o_busy(busy), .o_meas_valid(valid),
      .i_meas_ready(ready), .o_meas_sum(sum), .o_meas_inc(inc_o), .o_meas_wraps(wraps)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one clock: drive the PG stream model, advance it after the edge
   task automatic tick();
      cen      = gate ? (cyc % 3 == 0) : 1'b1;
      zero     = (ts == 5'd0);
      phase_in = ph[ts];
      @(posedge clk);
      #1;
      if (rst) ts = '0;
      else if (cen) begin
         ph[ts] = ph[ts] + stp[ts];
         ts     = ts + 5'd1;
      end
      cyc++;
      start = 1'b0;
   endtask

   task automatic setup(input int mode);
      for (int k = 0; k < 32; k++) begin
         ph[k]  = '0;
         stp[k] = (mode == 2) ? 20'(100 * k) : 20'(37 * k + 1);
      end
      if (mode != 2) stp[5] = 20'd1000;
      if (mode == 1) ph[5] = 20'hFFE00;
   endtask

   task automatic chk_outs(input string tag, input int es, input int ei, input int ew);
      chk({tag, ".sum"}, sum, es);
      chk({tag, ".inc"}, inc_o, ei);
      chk({tag, ".wraps"}, wraps, ew);
   endtask

   task automatic meas(input string tag, input int mode, input logic [4:0] s,
                       input int es, input int ei, input int ew, input int elat,
                       input bit poke, input bit hold, input int abort_at);
      int n;
      for (int i = 0; i < 200 && ts != 5'd0; i++) tick();
      setup(mode);
      sel   = s;
      start = 1'b1;
      tick();
      chk({tag, ".busy_on"}, busy, 1);
      n = 0;
      while (!valid && n < 4000) begin
         if (poke && n == 100) begin
            start = 1'b1;
            sel   = 5'd3;
         end
         if (abort_at > 0 && n == abort_at) begin
            rst = 1'b1;
            tick();
            chk({tag, ".rst_busy"}, busy, 0);
            chk({tag, ".rst_valid"}, valid, 0);
            chk_outs({tag, ".rst"}, 0, 0, 0);
            rst = 1'b0;
            tick();
            return;
         end
         tick();
         n++;
      end
      chk({tag, ".valid"}, valid, 1);
      if (elat >= 0) chk({tag, ".latency"}, n, elat);
      chk({tag, ".busy_done"}, busy, 0);
      chk_outs(tag, es, ei, ew);
      if (hold) begin
         for (int i = 0; i < 100; i++) begin
            if (i % 25 == 0) begin
               start = 1'b1;
               sel   = 5'd9;
            end
            tick();
         end
         chk({tag, ".hold_valid"}, valid, 1);
         chk({tag, ".hold_busy"}, busy, 0);
         chk_outs({tag, ".hold"}, es, ei, ew);
      end
      ready = 1'b1;
      start = 1'b1;
      tick();
      ready = 1'b0;
      chk({tag, ".ack_valid"}, valid, 0);
      chk({tag, ".ack_busy"}, busy, 0);
   endtask

   initial begin
      setup(0);
      repeat (3) tick();
      chk("reset.busy", busy, 0);
      chk("reset.valid", valid, 0);
      chk_outs("reset", 0, 0, 0);
      rst = 1'b0;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("idle_ready.valid", valid, 0);
      meas("const", 0, 5'd5, 16000, 1000, 0, 517, 1'b1, 1'b1, 0);
      meas("wrap", 1, 5'd5, 16000, 1000, 1, 517, 1'b0, 1'b0, 0);
      meas("slot31", 2, 5'd31, 49600, 3100, 0, 543, 1'b0, 1'b0, 0);
      meas("slot0", 2, 5'd0, 0, 0, 0, 544, 1'b0, 1'b0, 0);
      gate = 1'b1;
      meas("gated", 0, 5'd5, 16000, 1000, 0, -1, 1'b0, 1'b0, 0);
      gate = 1'b0;
      meas("abort", 0, 5'd5, 0, 0, 0, -1, 1'b0, 1'b0, 150);
      meas("fresh", 0, 5'd5, 16000, 1000, 0, 517, 1'b0, 1'b0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/jt51_phinc_meas.md
# jt51_phinc_meas

Phase-increment monitor for the JT51 phase generator. It sits on the phase output of the PG and follows the 32-slot time-multiplexed stream. On request it captures the phase of one selected slot on consecutive visits and sums the modulo-2^PW increments over 2^NLOG samples. It then presents the sum, the average increment and the wrap count on a valid/ready result port, so benches can compare measured increments against kc/kf/mul/dt1/dt2/pm sweeps.

## Interface
Parameters:
- PW, 20, phase width in bits
- NLOG, 4, log2 of the number of increments accumulated per measurement (1..8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock enable; one slot advances per clk with cen=1
- zero  in  1  high, qualified by cen, during the slot-0 cycle
- phase_in  in  PW  phase output of the PG for the current slot
- start  in  1  measurement request, single-cycle pulse
- sel_slot  in  5  slot to measure; sampled with start
- busy  out  1  measurement armed or running
- meas_valid  out  1  result available
- meas_ready  in  1  result consumed
- meas_sum  out  PW+NLOG  sum of the 2^NLOG increments
- meas_inc  out  PW  meas_sum >> NLOG (truncating)
- meas_wraps  out  NLOG+1  number of increments where phase_in < previous phase

## Operation
- Slot counter, 5 bits, reset 0. On cen: zero=1 loads 1; otherwise the counter increments and wraps 31->0. The current slot is 0 when zero=1, else the counter value.
- Sample event: cen=1 and current slot == sel_q.
- FSM states IDLE, ARM, RUN, DONE. Reset state is IDLE.
- IDLE: busy=0, meas_valid=0. start=1 latches sel_q<=sel_slot, clears sum, wraps and n, then goes to ARM.
- ARM: busy=1. A sample event sets prev<=phase_in and goes to RUN. The first visit only sets the reference and is not accumulated.
- RUN: busy=1. A sample event computes delta=(phase_in-prev) mod 2^PW and updates sum+=delta, wraps+=(phase_in<prev), prev<=phase_in, n+=1.
- RUN to DONE: the sample event on which n reaches 2^NLOG goes to DONE. The same edge registers meas_sum, meas_inc and meas_wraps.
- DONE: meas_valid=1 and busy=0. meas_ready=1 returns to IDLE and clears meas_valid.
- start is ignored in ARM, RUN and DONE. start in the same cycle as the DONE->IDLE transfer is also ignored and must be re-pulsed.
- Arithmetic: the sum cannot overflow, since the maximum is (2^PW-1)*2^NLOG and fits in PW+NLOG bits. A delta of 0 is legal.
- sel_slot changes after start have no effect until the next accepted start.
- cen=0 freezes the slot counter, the FSM sampling and all data registers. The handshake (meas_ready) is still honoured with cen=0.

## Timing
- Reset values: busy=0, meas_valid=0, meas_sum=0, meas_inc=0, meas_wraps=0, slot counter 0, FSM IDLE.
- Reset asserted mid-measurement aborts immediately to the reset values. No partial result is presented.
- start sampled at edge T gives busy=1 after T.
- With cen tied high, a measurement spans 2^NLOG+1 visits of the selected slot. That is at most 32 + 32·2^NLOG cycles after start, including up to 32 cycles waiting for the first visit.
- meas_valid rises on the clk edge of the final sample event. Results are valid in the same cycle meas_valid is seen high.
- Outputs hold stable while meas_valid=1 and meas_ready=0, for any duration.
- meas_ready with meas_valid=0 has no effect.

## Test plan
- Constant increment: cen=1, NLOG=4, slot 5 phase advances by 1000 per visit from 0, sel_slot=5 -> meas_sum=16000, meas_inc=1000, meas_wraps=0, meas_valid about 32·17 cycles after start.
- Wrap-around: PW=20, slot 5 phase starts at 0xFFE00 and advances by 1000 per visit -> meas_inc=1000 and meas_wraps=1, with a single visit wrapping.
- Slot isolation: every slot k advances by 100·k per visit, sel_slot=31 -> meas_inc=3100. Repeat with sel_slot=0 -> meas_inc=0.
- cen gating: the constant-increment case with cen toggling 1,0,0,1,… -> identical results; only the latency scales with the cen duty.
- Backpressure and start rules: hold meas_ready=0 for 100 cycles -> outputs stay constant and busy=0. start pulses during RUN and during DONE are ignored, with sel_q unchanged. Raise meas_ready -> IDLE on the next edge.
- Reset mid-RUN: assert rst after 5 samples -> all outputs 0 and IDLE. A fresh start yields a correct full measurement.
